// File: rtl/mul_seq_shared.sv
// Shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH; every addition (partial products and the
// bit-counter increment) is done on an external shared adder. Define MUL_SIGNED_EN for signed_i.
module mul_seq_shared #(
  parameter int WIDTH = 8,
  parameter int CTR_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               start,
`ifdef MUL_SIGNED_EN
  input  logic               signed_i,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] sum_in_a,
  output logic [2*WIDTH-1:0] sum_in_b,
  input  logic [2*WIDTH-1:0] sum_out
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, SUM, INC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CTR_W-1:0] ctr_q;
  logic [PW-1:0]    result_q;
  logic             busy_q, done_q, signed_q;
  logic             sgn_in;

  logic [PW-1:0]    a_ext, pp_sh;
  logic [WIDTH-1:0] b_rest;
  logic             last_bit, sum_exit;
  logic [PW-1:0]    adder_a, adder_b;

`ifdef MUL_SIGNED_EN
  assign sgn_in = signed_i;
`else
  assign sgn_in = 1'b0;
`endif

  assign a_ext    = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign last_bit = (ctr_q == CTR_W'(WIDTH - 1));
  assign b_rest   = b_q >> ctr_q;
  // Stop as soon as no multiplier bits remain above the current one.
  assign sum_exit = last_bit || (b_rest[WIDTH-1:1] == '0);

  always_comb begin
    pp_sh = b_q[ctr_q] ? (a_ext << ctr_q) : '0;
    // The sign bit of a two's-complement multiplier carries negative weight.
    if (signed_q && last_bit) begin
      pp_sh = -pp_sh;
    end
  end

  always_comb begin
    adder_a = '0;
    adder_b = '0;
    case (state_q)
      SUM: begin
        adder_a = pp_sh;
        adder_b = result_q;
      end
      INC: begin
        adder_a = {{(PW - CTR_W){1'b0}}, ctr_q};
        adder_b = PW'(1);
      end
      default: begin
        adder_a = '0;
        adder_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctr_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a_i;
            b_q      <= b_i;
            signed_q <= sgn_in;
            result_q <= '0;
            ctr_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SUM;
          end
        end
        SUM: begin
          result_q <= sum_out;
          if (sum_exit) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= INC;
          end
        end
        INC: begin
          ctr_q   <= sum_out[CTR_W-1:0];
          state_q <= SUM;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign sum_in_a = adder_a;
  assign sum_in_b = adder_b;

endmodule

// File: tb/tb_mul_seq_shared.sv
// Directed bench for mul_seq_shared: 8-bit vector table, reset abort, and a 16-bit full-length run.
module tb_mul_seq_shared;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp_res;
    int          exp_busy;
    logic        inj;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic        busy8, done8;
  logic [15:0] res8, sa8, sb8, so8;

  logic [15:0] a16 = '0, b16 = '0;
  logic        start16 = 1'b0;
  logic        busy16, done16;
  logic [31:0] res16, sa16, sb16, so16;

  int pass_cnt = 0;
  int total    = 0;
  int viol     = 0;

  vec_t vecs[$];

  assign so8  = sa8 + sb8;
  assign so16 = sa16 + sb16;

  always #5 clk = ~clk;

  mul_seq_shared #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a_i(a8), .b_i(b8), .start(start8),
`ifdef MUL_SIGNED_EN
    .signed_i(sgn8),
`endif
    .busy(busy8), .done(done8), .result(res8),
    .sum_in_a(sa8), .sum_in_b(sb8), .sum_out(so8)
  );

  mul_seq_shared #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .a_i(a16), .b_i(b16), .start(start16),
`ifdef MUL_SIGNED_EN
    .signed_i(1'b0),
`endif
    .busy(busy16), .done(done16), .result(res16),
    .sum_in_a(sa16), .sum_in_b(sb16), .sum_out(so16)
  );

  // Adder inputs must be idle whenever the block is not busy.
  always @(negedge clk) begin
    if (!busy8 && (sa8 != '0 || sb8 != '0)) viol++;
    if (!busy16 && (sa16 != '0 || sb16 != '0)) viol++;
  end

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic s,
                              input logic [15:0] e, input int cyc, input logic inj);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.exp_res = e; v.exp_busy = cyc; v.inj = inj;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic inj,
                      output int nbusy, output logic seen, output logic again,
                      output logic [15:0] first_res);
    @(negedge clk);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    first_res = res8;
    nbusy = 0; seen = 1'b0; again = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done8) begin
        seen = 1'b1;
        break;
      end
      if (busy8) nbusy++;
      start8 = inj && (i == 1 || i == 3);
      if (start8) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    @(negedge clk);
    again = done8;
  endtask

  initial begin
    int          nb;
    logic        seen, again, done_in_rst;
    logic [15:0] fr;

    vecs.push_back(mk(8'hFF, 8'hFF, 1'b0, 16'hFE01, 15, 1'b0));
    vecs.push_back(mk(8'h37, 8'h00, 1'b0, 16'h0000,  1, 1'b0));
    vecs.push_back(mk(8'h0D, 8'h05, 1'b0, 16'h0041,  5, 1'b1));
    vecs.push_back(mk(8'h01, 8'h80, 1'b0, 16'h0080, 15, 1'b0));
    vecs.push_back(mk(8'h12, 8'h03, 1'b0, 16'h0036,  3, 1'b0));
    vecs.push_back(mk(8'hFF, 8'h01, 1'b0, 16'h00FF,  1, 1'b0));
`ifdef MUL_SIGNED_EN
    vecs.push_back(mk(8'hFD, 8'h05, 1'b1, 16'hFFF1,  5, 1'b0));
    vecs.push_back(mk(8'h02, 8'hFF, 1'b1, 16'hFFFE, 15, 1'b0));
    vecs.push_back(mk(8'hFD, 8'h05, 1'b0, 16'h04F1,  5, 1'b0));
`endif

    #1;
    chk("rst_busy",   64'(busy8), 64'd0);
    chk("rst_done",   64'(done8), 64'd0);
    chk("rst_result", 64'(res8),  64'd0);
    chk("rst_sum_a",  64'(sa8),   64'd0);
    chk("rst_sum_b",  64'(sb8),   64'd0);
    chk("rst_res16",  64'(res16), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].inj, nb, seen, again, fr);
      chk($sformatf("v%0d_result", i),     64'(res8), 64'(vecs[i].exp_res));
      chk($sformatf("v%0d_busy_cyc", i),   64'(nb),   64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_seen", i),  64'(seen), 64'd1);
      chk($sformatf("v%0d_done_pulse", i), 64'(again), 64'd0);
      chk($sformatf("v%0d_cleared", i),    64'(fr),   64'd0);
    end

    // Reset while in INC (second busy cycle) aborts without a done pulse.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'hFF; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("abort_pre_busy", 64'(busy8), 64'd1);
    chk("abort_pre_res",  64'(res8),  64'h00AA);
    rst = 1'b0;
    #1;
    chk("abort_busy",   64'(busy8), 64'd0);
    chk("abort_result", 64'(res8),  64'd0);
    done_in_rst = done8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done8) done_in_rst = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done8) done_in_rst = 1'b1;
    chk("abort_no_done", 64'(done_in_rst), 64'd0);
    run8(8'h03, 8'h04, 1'b0, 1'b0, nb, seen, again, fr);
    chk("post_abort_result", 64'(res8), 64'h000C);
    chk("post_abort_busy",   64'(nb),   64'd5);

    // 16-bit full-length run.
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h8001; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done16) begin
        seen = 1'b1;
        break;
      end
      if (busy16) nb++;
      @(negedge clk);
    end
    chk("w16_result",    64'(res16), 64'h8000_7FFF);
    chk("w16_busy_cyc",  64'(nb),    64'd31);
    chk("w16_done_seen", 64'(seen),  64'd1);
    @(negedge clk);
    chk("w16_done_pulse", 64'(done16), 64'd0);

    chk("adder_idle_zero", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
